// File: rtl/action_command_generator.sv
// Two-player action command generator: collects one valid code from each player per round,
// defaults a straggler after a timeout, then strobes both codes to the game core.
module action_command_generator #(
    parameter int          ENABLE_HIGH_CYCLES = 1,
    parameter int          TIMEOUT_CYCLES     = 1000,
    parameter logic [2:0]  DEFAULT_ACTION     = 3'b000
) (
    input  logic       clk,
    input  logic       resetGame,
    input  logic [2:0] sel1,
    input  logic       commit1,
    input  logic [2:0] sel2,
    input  logic       commit2,
    input  logic       firstWin,
    input  logic       secondWin,
    output logic [2:0] action1,
    output logic [2:0] action2,
    output logic       actionEnable,
    output logic       waiting1,
    output logic       waiting2,
    output logic [7:0] roundCount,
    output logic       halted
);

    typedef enum logic [1:0] {COLLECT, ISSUE, GAP, HALT} state_t;

    state_t      state;
    logic [2:0]  lat1;
    logic [2:0]  lat2;
    logic [15:0] tcnt;
    logic [3:0]  ecnt;

    logic       take1;
    logic       take2;
    logic       got1;
    logic       got2;
    logic       timeoutHit;
    logic       roundDone;
    logic [2:0] fin1;
    logic [2:0] fin2;

    // waiting flags double as the "not yet committed" record while collecting
    always_comb begin
        take1      = commit1 && (sel1 != 3'b111) && waiting1;
        take2      = commit2 && (sel2 != 3'b111) && waiting2;
        got1       = !waiting1 || take1;
        got2       = !waiting2 || take2;
        timeoutHit = (waiting1 ^ waiting2) && (tcnt == 16'(TIMEOUT_CYCLES - 2));
        roundDone  = (got1 && got2) || timeoutHit;
        fin1       = take1 ? sel1 : (got1 ? lat1 : DEFAULT_ACTION);
        fin2       = take2 ? sel2 : (got2 ? lat2 : DEFAULT_ACTION);
    end

    always_ff @(posedge clk) begin
        if (resetGame) begin
            state        <= COLLECT;
            action1      <= 3'b000;
            action2      <= 3'b000;
            actionEnable <= 1'b0;
            waiting1     <= 1'b1;
            waiting2     <= 1'b1;
            roundCount   <= 8'd0;
            halted       <= 1'b0;
            lat1         <= 3'b000;
            lat2         <= 3'b000;
            tcnt         <= 16'd0;
            ecnt         <= 4'd0;
        end else if (firstWin || secondWin) begin
            // game over wins even against a round completing on this edge
            state        <= HALT;
            actionEnable <= 1'b0;
            waiting1     <= 1'b0;
            waiting2     <= 1'b0;
            halted       <= 1'b1;
        end else begin
            case (state)
                COLLECT: begin
                    if (roundDone) begin
                        state        <= ISSUE;
                        action1      <= fin1;
                        action2      <= fin2;
                        actionEnable <= 1'b1;
                        waiting1     <= 1'b0;
                        waiting2     <= 1'b0;
                        tcnt         <= 16'd0;
                        ecnt         <= 4'd0;
                        if (roundCount != 8'hFF)
                            roundCount <= roundCount + 8'd1;
                    end else begin
                        if (take1) begin
                            lat1     <= sel1;
                            waiting1 <= 1'b0;
                        end
                        if (take2) begin
                            lat2     <= sel2;
                            waiting2 <= 1'b0;
                        end
                        if (waiting1 && waiting2)
                            tcnt <= 16'd0;
                        else
                            tcnt <= tcnt + 16'd1;
                    end
                end
                ISSUE: begin
                    if (ecnt == 4'(ENABLE_HIGH_CYCLES - 1)) begin
                        state        <= GAP;
                        actionEnable <= 1'b0;
                    end else begin
                        ecnt <= ecnt + 4'd1;
                    end
                end
                GAP: begin
                    state    <= COLLECT;
                    waiting1 <= 1'b1;
                    waiting2 <= 1'b1;
                    lat1     <= 3'b000;
                    lat2     <= 3'b000;
                    tcnt     <= 16'd0;
                end
                default: begin
                    actionEnable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_action_command_generator.sv
// Randomized and directed stimulus against a timestamp-based round model, with a
// queue of expected issued rounds consumed by an independent monitor.
module tb_action_command_generator;

    localparam int         EHC = 3;
    localparam int         TO  = 8;
    localparam logic [2:0] DEF = 3'b101;

    logic       clk = 1'b0;
    logic       resetGame = 1'b1;
    logic [2:0] sel1 = 3'b000;
    logic       commit1 = 1'b0;
    logic [2:0] sel2 = 3'b000;
    logic       commit2 = 1'b0;
    logic       firstWin = 1'b0;
    logic       secondWin = 1'b0;
    logic [2:0] action1;
    logic [2:0] action2;
    logic       actionEnable;
    logic       waiting1;
    logic       waiting2;
    logic [7:0] roundCount;
    logic       halted;

    action_command_generator #(
        .ENABLE_HIGH_CYCLES(EHC),
        .TIMEOUT_CYCLES(TO),
        .DEFAULT_ACTION(DEF)
    ) dut (
        .clk(clk),
        .resetGame(resetGame),
        .sel1(sel1),
        .commit1(commit1),
        .sel2(sel2),
        .commit2(commit2),
        .firstWin(firstWin),
        .secondWin(secondWin),
        .action1(action1),
        .action2(action2),
        .actionEnable(actionEnable),
        .waiting1(waiting1),
        .waiting2(waiting2),
        .roundCount(roundCount),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] a1;
        logic [2:0] a2;
        int         rc;
    } round_t;

    round_t expQ[$];

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    // reference model: rounds tracked by the edge index they started and completed at
    int         n = 0;
    bit         mH = 1'b0;
    bit         mGot1 = 1'b0;
    bit         mGot2 = 1'b0;
    logic [2:0] mC1 = 3'b000;
    logic [2:0] mC2 = 3'b000;
    int         mFirst = 0;
    int         mDone = -100;
    int         mBusyEnd = -1;
    int         mRc = 0;
    logic [2:0] mA1 = 3'b000;
    logic [2:0] mA2 = 3'b000;
    bit         mEn = 1'b0;
    bit         mW1 = 1'b1;
    bit         mW2 = 1'b1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at edge %0d", name, act, exp, n);
        end
    endtask

    task automatic modelEdge(input bit rst, input logic [2:0] s1, input bit c1,
                             input logic [2:0] s2, input bit c2, input bit win);
        bit t1, t2, prevOne, complete;
        round_t r;
        if (rst) begin
            mH = 0; mGot1 = 0; mGot2 = 0; mC1 = 0; mC2 = 0;
            mBusyEnd = -1; mDone = -100; mRc = 0; mA1 = 0; mA2 = 0;
            mEn = 0; mW1 = 1; mW2 = 1;
        end else if (mH) begin
            mEn = 0;
        end else if (win) begin
            mH = 1; mEn = 0; mW1 = 0; mW2 = 0;
        end else if (n <= mBusyEnd) begin
            mEn = (n <= mDone + EHC - 1);
            if (n == mBusyEnd) begin
                mGot1 = 0; mGot2 = 0; mW1 = 1; mW2 = 1;
            end
        end else begin
            prevOne  = mGot1 ^ mGot2;
            t1       = c1 && (s1 != 3'b111) && !mGot1;
            t2       = c2 && (s2 != 3'b111) && !mGot2;
            complete = 0;
            if (!mGot1 && !mGot2 && (t1 || t2)) mFirst = n;
            if (t1) begin mGot1 = 1; mC1 = s1; end
            if (t2) begin mGot2 = 1; mC2 = s2; end
            if (mGot1 && mGot2) complete = 1;
            else if (prevOne && (n - mFirst == TO - 1)) begin
                if (!mGot1) mC1 = DEF;
                if (!mGot2) mC2 = DEF;
                complete = 1;
            end
            if (complete) begin
                mRc = (mRc < 255) ? mRc + 1 : 255;
                mA1 = mC1; mA2 = mC2;
                r.a1 = mC1; r.a2 = mC2; r.rc = mRc;
                expQ.push_back(r);
                mDone = n; mBusyEnd = n + EHC + 1;
                mEn = 1; mW1 = 0; mW2 = 0;
            end else begin
                mW1 = !mGot1; mW2 = !mGot2;
            end
        end
        n++;
    endtask

    task automatic applyStimulus(input bit rst, input logic [2:0] s1, input bit c1,
                                 input logic [2:0] s2, input bit c2, input bit fw, input bit sw);
        @(negedge clk);
        resetGame = rst; sel1 = s1; commit1 = c1; sel2 = s2; commit2 = c2;
        firstWin = fw; secondWin = sw;
        modelEdge(rst, s1, c1, s2, c2, fw | sw);
        started = 1'b1;
        @(posedge clk);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(0, 3'b000, 0, 3'b000, 0, 0, 0);
    endtask

    // monitor: per-cycle flags against the model, issued rounds against the queue
    initial begin
        logic prevEn;
        round_t r;
        prevEn = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                checkOutput("actionEnable", 32'(actionEnable), 32'(mEn));
                checkOutput("waiting1", 32'(waiting1), 32'(mW1));
                checkOutput("waiting2", 32'(waiting2), 32'(mW2));
                checkOutput("halted", 32'(halted), 32'(mH));
                checkOutput("roundCount", 32'(roundCount), 32'(mRc));
                checkOutput("action1_hold", 32'(action1), 32'(mA1));
                checkOutput("action2_hold", 32'(action2), 32'(mA2));
                if (actionEnable === 1'b1 && prevEn !== 1'b1) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_issue", 32'(1), 32'(0));
                    end else begin
                        r = expQ.pop_front();
                        checkOutput("issue_action1", 32'(action1), 32'(r.a1));
                        checkOutput("issue_action2", 32'(action2), 32'(r.a2));
                        checkOutput("issue_roundCount", 32'(roundCount), 32'(r.rc));
                    end
                end
                prevEn = actionEnable;
            end
        end
    end

    initial begin
        bit rst, fw, sw, c1, c2;
        logic [2:0] s1, s2;
        applyStimulus(1, 3'b000, 0, 3'b000, 0, 0, 0);
        applyStimulus(1, 3'b000, 0, 3'b000, 0, 0, 0);
        idle(3);

        // both players on one edge
        applyStimulus(0, 3'b110, 1, 3'b100, 1, 0, 0);
        idle(6);
        // lone player defaulted after timeout
        applyStimulus(0, 3'b001, 1, 3'b000, 0, 0, 0);
        idle(12);
        // repeat commit and invalid code ignored
        applyStimulus(0, 3'b011, 1, 3'b000, 0, 0, 0);
        applyStimulus(0, 3'b010, 1, 3'b000, 0, 0, 0);
        applyStimulus(0, 3'b000, 0, 3'b111, 1, 0, 0);
        applyStimulus(0, 3'b000, 0, 3'b010, 1, 0, 0);
        idle(6);
        // commits pulsed during ISSUE and GAP are dropped
        applyStimulus(0, 3'b001, 1, 3'b010, 1, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 3'b100, 1, 3'b011, 1, 0, 0);
        idle(4);
        // win mid-issue, commits ignored in HALT, then reset
        applyStimulus(0, 3'b101, 1, 3'b110, 1, 0, 0);
        applyStimulus(0, 3'b000, 0, 3'b000, 0, 0, 0);
        applyStimulus(0, 3'b000, 0, 3'b000, 0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 3'b010, 1, 3'b001, 1, 0, 0);
        applyStimulus(1, 3'b000, 0, 3'b000, 0, 0, 0);
        idle(3);
        // round completion coinciding with a win flag
        applyStimulus(0, 3'b011, 1, 3'b011, 1, 1, 0);
        applyStimulus(1, 3'b000, 0, 3'b000, 0, 0, 0);
        // reset mid-issue
        applyStimulus(0, 3'b010, 1, 3'b001, 1, 0, 0);
        applyStimulus(1, 3'b000, 0, 3'b000, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            fw  = ($urandom_range(0, 399) == 0);
            sw  = ($urandom_range(0, 399) == 0);
            c1  = ($urandom_range(0, 3) == 0);
            c2  = ($urandom_range(0, 5) == 0);
            s1  = 3'($urandom_range(0, 7));
            s2  = 3'($urandom_range(0, 7));
            if (halted === 1'b1 && $urandom_range(0, 19) == 0) rst = 1;
            applyStimulus(rst, s1, c1, s2, c2, fw, sw);
        end

        // saturation of the round counter
        applyStimulus(1, 3'b000, 0, 3'b000, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(0, 3'(i % 7), 1, 3'((i + 3) % 7), 1, 0, 0);
            idle(EHC + 1);
        end
        idle(10);
        checkOutput("queue_drained", 32'(expQ.size()), 32'(0));
        checkOutput("final_roundCount", 32'(roundCount), 32'(255));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/action_command_generator.md
ACTION_COMMAND_GENERATOR -- requirements
Module: action_command_generator

Interface
REQ-001 The block SHALL have parameter ENABLE_HIGH_CYCLES, default 1, giving the number of clocks actionEnable stays high per issued round (legal range 1..15).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, giving the clocks allowed after the first commit of a round before the missing player is defaulted (legal range 2..65535).
REQ-003 The block SHALL have parameter DEFAULT_ACTION, default 3'b000, the code substituted for a player who has not committed by timeout.
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 resetGame  input  1  synchronous, active-high reset.
REQ-006 sel1  input  3  player-1 requested action code.
REQ-007 commit1  input  1  player-1 commit strobe; sel1 is sampled on any edge where commit1 is high.
REQ-008 sel2  input  3  player-2 requested action code.
REQ-009 commit2  input  1  player-2 commit strobe; sel2 is sampled on any edge where commit2 is high.
REQ-010 firstWin  input  1  game-over flag from the game core, player 1 won.
REQ-011 secondWin  input  1  game-over flag from the game core, player 2 won.
REQ-012 action1  output  3  registered player-1 action code presented to the game core.
REQ-013 action2  output  3  registered player-2 action code presented to the game core.
REQ-014 actionEnable  output  1  registered strobe; the game core consumes action1/action2 while it is high.
REQ-015 waiting1  output  1  high while player 1 has not yet committed in the current round.
REQ-016 waiting2  output  1  high while player 2 has not yet committed in the current round.
REQ-017 roundCount  output  8  number of rounds issued since reset, saturating at 255.
REQ-018 halted  output  1  high in HALT state.

Function
REQ-019 The FSM SHALL have states COLLECT, ISSUE, GAP, HALT.
REQ-020 In COLLECT, a commit with code != 3'b111 for an uncommitted player SHALL latch that code and clear the corresponding waiting flag at that edge.
REQ-021 Code 3'b111 SHALL be treated as invalid: the commit is ignored and the player stays waiting.
REQ-022 A second commit from an already-committed player in the same round SHALL be ignored; the first latched code is kept.
REQ-023 Commits from both players on the same edge SHALL both latch.
REQ-024 The timeout counter SHALL start at 0 on the edge of the first valid commit of a round and increment each clock in COLLECT while exactly one player has committed.
REQ-025 When the counter reaches TIMEOUT_CYCLES-1, the waiting player's code SHALL become DEFAULT_ACTION on that edge, completing the round.
REQ-026 On the edge at which a round completes, the FSM SHALL enter ISSUE, drive action1/action2 with the latched codes, set actionEnable=1, and increment roundCount (saturating).
REQ-027 actionEnable SHALL stay high for exactly ENABLE_HIGH_CYCLES clocks, then the FSM SHALL enter GAP with actionEnable=0 for exactly 1 clock, then return to COLLECT with waiting1=waiting2=1.
REQ-028 action1/action2 SHALL hold their values from ISSUE entry until the next ISSUE entry.
REQ-029 Commits during ISSUE or GAP SHALL be ignored; they are not queued.
REQ-030 With no commits, COLLECT SHALL persist indefinitely and the timeout counter SHALL stay at 0.
REQ-031 If firstWin or secondWin is high on any edge in any state, the FSM SHALL enter HALT on that edge, forcing actionEnable=0, including aborting an ISSUE in progress.
REQ-032 In HALT, all commits SHALL be ignored, outputs SHALL hold except actionEnable=0 and waiting1=waiting2=0, and only resetGame SHALL exit.
REQ-033 If a round completes on the same edge that a win flag is high, HALT SHALL take priority and roundCount SHALL NOT increment.

Reset
REQ-034 resetGame high on an edge SHALL, with priority over all other inputs, set state=COLLECT, action1=action2=3'b000, actionEnable=0, waiting1=waiting2=1, roundCount=0, halted=0, timeout counter=0, and clear latched codes.
REQ-035 Reset asserted mid-ISSUE SHALL drop actionEnable on that edge, and no partial round SHALL be counted.

Verification
REQ-036 Reset, then commit1 with sel1=3'b110 and commit2 with sel2=3'b100 on the same edge -> next cycle action1=110, action2=100, actionEnable=1 for 1 clock, 0 for 1 clock, roundCount=1.
REQ-037 commit1 with 3'b001 at edge E, no commit2, TIMEOUT_CYCLES=8 -> at edge E+7 action1=001, action2=000, actionEnable=1.
REQ-038 commit1=3'b011, then commit1=3'b010, then commit2=3'b111, then commit2=3'b010 -> issued action1=011, action2=010, and waiting2 stays 1 after the 3'b111 commit.
REQ-039 ENABLE_HIGH_CYCLES=3, with commits pulsed during ISSUE -> actionEnable high exactly 3 clocks, ignored commits do not start a new round, and waiting1=waiting2=1 after GAP.
REQ-040 secondWin raised during the 2nd ISSUE clock with ENABLE_HIGH_CYCLES=3 -> actionEnable=0 on the next edge, halted=1, later commits are ignored, and resetGame restores all REQ-034 values.
REQ-041 300 completed rounds -> roundCount=255.
